// File: rtl/ternary_neuron_accum_if.sv
// Handshake bundle for the ternary neuron accumulator: the beat input channel
// (popcount pair plus in_last) and the held trit result channel.
interface ternary_neuron_accum_if #(
    parameter int ACC_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [4:0]       pos_count;
    logic [4:0]       neg_count;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_trit;
    logic [ACC_W-1:0] out_sum;
    logic             out_overrun;

    // Producer of beats and consumer of results.
    modport master (
        output in_valid, in_last, pos_count, neg_count, out_ready,
        input  in_ready, out_valid, out_trit, out_sum, out_overrun
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_last, pos_count, neg_count, out_ready,
        output in_ready, out_valid, out_trit, out_sum, out_overrun
    );
endinterface

// File: rtl/ternary_neuron_accum.sv
// Accumulates (pos_count - neg_count) over a multi-beat neuron and thresholds the sum to a trit.
// Optional TNA_COUNT_CLAMP_EN: clamp each popcount to 27 before subtracting.
//
// state | meaning
// ACCUM | accepting beats, acc holds the saturating partial sum
// HOLD  | result registered and presented until out_ready
module ternary_neuron_accum #(
    parameter int MAX_BEATS = 4,
    parameter int ACC_W     = 9,
    parameter int THR_HI    = 8,
    parameter int THR_LO    = -8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ternary_neuron_accum_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [3:0]               LAST_BEAT = 4'(MAX_BEATS - 1);
    localparam logic signed [ACC_W:0]    SAT_MAX   = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]    SAT_MIN   = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  THR_HI_V  = ACC_W'(THR_HI);
    localparam logic signed [ACC_W-1:0]  THR_LO_V  = ACC_W'(THR_LO);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [3:0]              beat_cnt;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [1:0]              out_trit_q;
    logic [ACC_W-1:0]        out_sum_q;
    logic                    out_overrun_q;

    logic [4:0]              pos_eff;
    logic [4:0]              neg_eff;
    logic signed [5:0]       delta;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] acc_next;
    logic [1:0]              trit_next;
    logic                    accept;
    logic                    at_last_beat;
    logic                    close;

`ifdef TNA_COUNT_CLAMP_EN
    // The approximate popcount may report up to 31 for only 27 real inputs.
    assign pos_eff = (bus.pos_count > 5'd27) ? 5'd27 : bus.pos_count;
    assign neg_eff = (bus.neg_count > 5'd27) ? 5'd27 : bus.neg_count;
`else
    assign pos_eff = bus.pos_count;
    assign neg_eff = bus.neg_count;
`endif

    assign delta    = $signed({1'b0, pos_eff}) - $signed({1'b0, neg_eff});
    assign sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-5){delta[5]}}, delta};

    always_comb begin
        acc_next = sum_wide[ACC_W-1:0];
        if (sum_wide > SAT_MAX) begin
            acc_next = SAT_MAX[ACC_W-1:0];
        end else if (sum_wide < SAT_MIN) begin
            acc_next = SAT_MIN[ACC_W-1:0];
        end
    end

    always_comb begin
        trit_next = 2'b00;
        if (acc_next >= THR_HI_V) begin
            trit_next = 2'b01;
        end else if (acc_next <= THR_LO_V) begin
            trit_next = 2'b11;
        end
    end

    assign accept       = bus.in_valid & in_ready_q;
    assign at_last_beat = (beat_cnt == LAST_BEAT);
    assign close        = bus.in_last | at_last_beat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ACCUM;
            acc           <= '0;
            beat_cnt      <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_trit_q    <= 2'b00;
            out_sum_q     <= '0;
            out_overrun_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (close) begin
                            out_sum_q     <= acc_next;
                            out_trit_q    <= trit_next;
                            out_overrun_q <= ~bus.in_last & at_last_beat;
                            acc           <= '0;
                            beat_cnt      <= '0;
                            in_ready_q    <= 1'b0;
                            out_valid_q   <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            acc      <= acc_next;
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_trit    = out_trit_q;
    assign bus.out_sum     = out_sum_q;
    assign bus.out_overrun = out_overrun_q;
endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Scoreboard bench for ternary_neuron_accum: a reference model pushes expected
// results as beats are accepted; a monitor pops and compares on each output handshake.
module tb_ternary_neuron_accum;
    localparam int MAX_BEATS = 4;
    localparam int ACC_W     = 9;
    localparam int THR_HI    = 8;
    localparam int THR_LO    = -8;
    localparam int ACC_MAX   = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN   = -(1 << (ACC_W - 1));

    typedef struct {
        int sum;
        int trit;
        int overrun;
    } result_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rnd_bp   = 1'b0;

    result_t exp_q[$];
    int      m_acc   = 0;
    int      m_beats = 0;

    ternary_neuron_accum_if #(.ACC_W(ACC_W)) bus ();

    ternary_neuron_accum #(
        .MAX_BEATS (MAX_BEATS),
        .ACC_W     (ACC_W),
        .THR_HI    (THR_HI),
        .THR_LO    (THR_LO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_count(input int c);
`ifdef TNA_COUNT_CLAMP_EN
        return (c > 27) ? 27 : c;
`else
        return c;
`endif
    endfunction

    // Reference model: called for a beat that the DUT accepts at the coming edge.
    task automatic model_beat(input int p, input int n, input bit last);
        result_t r;
        m_acc = m_acc + eff_count(p) - eff_count(n);
        if (m_acc > ACC_MAX) m_acc = ACC_MAX;
        if (m_acc < ACC_MIN) m_acc = ACC_MIN;
        m_beats++;
        if (last || m_beats == MAX_BEATS) begin
            r.sum     = m_acc;
            r.trit    = (m_acc >= THR_HI) ? 1 : ((m_acc <= THR_LO) ? 3 : 0);
            r.overrun = (!last && m_beats == MAX_BEATS) ? 1 : 0;
            exp_q.push_back(r);
            m_acc   = 0;
            m_beats = 0;
        end
    endtask

    task automatic send_beat(input int p, input int n, input bit last);
        int guard = 0;
        bus.in_valid  = 1'b1;
        bus.pos_count = 5'(p);
        bus.neg_count = 5'(n);
        bus.in_last   = last;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            check_val("in_ready_timeout", 0, 1);
        end else begin
            model_beat(p, n, last);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.pos_count = $urandom_range(0, 31);
        bus.neg_count = $urandom_range(0, 31);
        bus.in_last   = $urandom_range(0, 1);
    endtask

    always @(negedge clk) begin
        result_t r;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected", 1, 0);
            end else begin
                r = exp_q.pop_front();
                check_val("sb_sum", int'($signed(bus.out_sum)), r.sum);
                check_val("sb_trit", int'(bus.out_trit), r.trit);
                check_val("sb_overrun", int'(bus.out_overrun), r.overrun);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            if (rnd_bp) bus.out_ready = $urandom_range(0, 1);
        end
    end

    initial begin
        int s_sum, s_trit, s_ovr, guard, len;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.pos_count = '0;
        bus.neg_count = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check_val("rst_out_valid", int'(bus.out_valid), 0);
        check_val("rst_in_ready", int'(bus.in_ready), 1);
        check_val("rst_out_trit", int'(bus.out_trit), 0);
        check_val("rst_out_sum", int'(bus.out_sum), 0);
        check_val("rst_overrun", int'(bus.out_overrun), 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_out_valid", int'(bus.out_valid), 0);

        send_beat(20, 5, 1'b1);
        check_val("latency_valid", int'(bus.out_valid), 1);
        check_val("hold_in_ready", int'(bus.in_ready), 0);

        send_beat(3, 10, 1'b0);
        send_beat(2, 9, 1'b1);
        send_beat(6, 6, 1'b1);

        repeat (4) send_beat(31, 0, 1'b0);
        repeat (4) send_beat(0, 31, 1'b0);

        // Threshold boundaries on both sides.
        send_beat(8, 0, 1'b1);
        send_beat(7, 0, 1'b1);
        send_beat(0, 8, 1'b1);
        send_beat(0, 7, 1'b1);

        // Backpressure: result must stay frozen while out_ready is low.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send_beat(12, 1, 1'b1);
        check_val("bp_valid", int'(bus.out_valid), 1);
        s_sum  = int'(bus.out_sum);
        s_trit = int'(bus.out_trit);
        s_ovr  = int'(bus.out_overrun);
        check_val("bp_sum_value", int'($signed(bus.out_sum)), 11);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check_val("bp_hold_valid", int'(bus.out_valid), 1);
            check_val("bp_hold_ready", int'(bus.in_ready), 0);
            check_val("bp_hold_sum", int'(bus.out_sum), s_sum);
            check_val("bp_hold_trit", int'(bus.out_trit), s_trit);
            check_val("bp_hold_ovr", int'(bus.out_overrun), s_ovr);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_valid", int'(bus.out_valid), 0);
        check_val("bp_release_ready", int'(bus.in_ready), 1);

        // Reset mid-neuron discards the partial sum.
        send_beat(10, 0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_acc   = 0;
        m_beats = 0;
        check_val("midrst_in_ready", int'(bus.in_ready), 1);
        check_val("midrst_out_valid", int'(bus.out_valid), 0);
        send_beat(1, 0, 1'b1);

        // Random neurons with input gaps and random output backpressure.
        rnd_bp = 1'b1;
        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_beat($urandom_range(0, 31), $urandom_range(0, 31), b == len - 1);
            end
        end
        rnd_bp = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("sb_drain", exp_q.size(), 0);
        check_val("final_in_ready", int'(bus.in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
